// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port synchronous memory.
// Zero-latency grants, one-cycle read response, fixed (with starvation guard) or round-robin priority.
module mem_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 13,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_if_req,
  input  logic [31:0]         i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [XLEN-1:0]     o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [XLEN/8-1:0]   i_d_be,
  input  logic [31:0]         i_d_addr,
  input  logic [XLEN-1:0]     i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [XLEN-1:0]     o_d_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [XLEN/8-1:0]   o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [XLEN-1:0]     o_mem_wdata,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_stall
);

  localparam int                BE_W     = XLEN / 8;
  localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  logic              rr_ptr_q, rr_ptr_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            rd_owner_q, rd_owner_d;

  logic if_gnt;
  logic d_gnt;
  logic both_req;

  // High address bits only alias within a region.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[31:ADDR_W-1], i_d_addr[31:ADDR_W-1]};

  assign both_req = i_if_req & i_d_req;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (i_if_req && !i_d_req) begin
        if_gnt = 1'b1;
      end else if (i_d_req && !i_if_req) begin
        d_gnt = 1'b1;
      end else if (both_req) begin
        if (RR_MODE != 0) begin
          if (rr_ptr_q) if_gnt = 1'b1;
          else          d_gnt  = 1'b1;
        end else begin
          // Starvation guard: fetch wins once it has been denied MAX_WAIT times in a row.
          if (wait_cnt_q == WAIT_LIM) if_gnt = 1'b1;
          else                        d_gnt  = 1'b1;
        end
      end
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_d_gnt  = d_gnt;
  assign o_stall  = (i_if_req & ~if_gnt) | (i_d_req & ~d_gnt);

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = {BE_W{1'b1}};
      o_mem_addr = {1'b0, i_if_addr[ADDR_W-2:0]};
    end else if (d_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_d_we;
      o_mem_be    = i_d_we ? i_d_be : {BE_W{1'b1}};
      o_mem_addr  = {1'b1, i_d_addr[ADDR_W-2:0]};
      o_mem_wdata = i_d_wdata;
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    rd_pend_d  = if_gnt | (d_gnt & ~i_d_we);
    rd_owner_d = d_gnt ? OWN_D : OWN_IF;
    if (if_gnt || d_gnt) begin
      rr_ptr_d = ~rr_ptr_q;
    end
    if (!i_if_req || if_gnt) begin
      wait_cnt_d = '0;
    end else if (RR_MODE == 0 && wait_cnt_q != WAIT_LIM) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= 1'b0;
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_IF;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // A read in flight when reset asserts is dropped rather than returned.
  assign o_if_rvalid = rst_n & rd_pend_q & (rd_owner_q == OWN_IF);
  assign o_d_rvalid  = rst_n & rd_pend_q & (rd_owner_q == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Cycle-accurate arbiter that multiplexes the core's instruction-fetch port and load/store data port onto one single-port synchronous memory. The memory is split into an instruction region (address MSB = 0) and a data region (address MSB = 1). The block replaces clock-phase multiplexing with a registered req/gnt/rvalid handshake. It adds a selectable fixed or round-robin priority, a fetch-starvation guard, byte-enabled writes and a stall output for the core's hazard unit.

## Interface
Parameters:
- XLEN, 32, data width; must be a multiple of 8
- ADDR_W, 13, memory word-address width; the MSB is the region select
- RR_MODE, 0, 0 = fixed data-first priority; 1 = round-robin
- MAX_WAIT, 4, in fixed mode, the number of consecutive denied fetch cycles before fetch is forced through (≥1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_if_req  in  1  fetch request
- i_if_addr  in  32  fetch address
- o_if_gnt  out  1  fetch granted this cycle
- o_if_rvalid  out  1  fetch data valid
- o_if_rdata  out  XLEN  fetch data
- i_d_req  in  1  load/store request
- i_d_we  in  1  1 = store, 0 = load
- i_d_be  in  XLEN/8  store byte enables
- i_d_addr  in  32  data address
- i_d_wdata  in  XLEN  store data
- o_d_gnt  out  1  data request granted this cycle
- o_d_rvalid  out  1  load data valid
- o_d_rdata  out  XLEN  load data
- o_mem_en  out  1  memory access enable
- o_mem_we  out  1  memory write
- o_mem_be  out  XLEN/8  memory byte enables
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  XLEN  memory write data
- i_mem_rdata  in  XLEN  memory read data, valid 1 cycle after an o_mem_en read
- o_stall  out  1  a request is pending and was not granted this cycle

## Operation
Grant and command generation (combinational from requests and state):
- At most one grant per cycle.
- When rst_n = 0, all grants, o_mem_en and o_mem_we are 0.

Memory command for a granted fetch:
- o_mem_addr = {1'b0, i_if_addr[ADDR_W-2:0]}
- o_mem_we = 0, o_mem_be = all ones

Memory command for a granted data request:
- o_mem_addr = {1'b1, i_d_addr[ADDR_W-2:0]}
- o_mem_we = i_d_we
- o_mem_be = i_d_we ? i_d_be : all ones
- o_mem_wdata = i_d_wdata

Command outputs when nothing is granted:
- o_mem_en = 0, o_mem_we = 0, o_mem_be = 0
- o_mem_addr = 0, o_mem_wdata = 0

Arbitration when only one port requests:
- That port is granted.

Arbitration when both ports request, RR_MODE = 0:
- Data is granted.
- wait_cnt increments on every cycle the fetch request is denied.
- When wait_cnt == MAX_WAIT, fetch is granted instead.
- wait_cnt clears on any fetch grant, and on any cycle i_if_req = 0.

Arbitration when both ports request, RR_MODE = 1:
- The port indicated by rr_ptr is granted.
- rr_ptr = 0 favours data; rr_ptr = 1 favours fetch.
- On every grant, rr_ptr moves to the other port, whether or not there was contention.

Read response tracking:
- Registered rd_owner and rd_pend are captured on each granted read: fetch, or a data request with i_d_we = 0.
- Stores produce no rvalid.

Stall:
- o_stall = (i_if_req & ~o_if_gnt) | (i_d_req & ~o_d_gnt).

Request rule:
- A requester holds req and its address/data stable until granted.

## Timing
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req when arbitration is won.
- Read latency is 1 cycle: rvalid is high exactly in the cycle after the grant.
- In an rvalid cycle, rdata = i_mem_rdata; when rvalid = 0, rdata = 0.
- A new grant may issue in the same cycle as the previous read's rvalid, giving full throughput of one access per cycle.

Reset values (rst_n = 0 sampled at an edge):
- rr_ptr = 0, wait_cnt = 0, rd_pend = 0.
- Both rvalid = 0 and both rdata = 0.

Reset mid-operation:
- A read granted in the cycle before reset is dropped: no rvalid follows reset release.
- In the first cycle after release, grants follow the normal arbitration rules.

Boundary conditions:
- Address bits at and above ADDR_W-1 are ignored, so high address bits alias within a region.
- A store followed immediately by a load of the same address returns the new data. This relies on memory write-before-next-read and needs no forwarding in this block.
- With RR_MODE = 0 and MAX_WAIT = 1, fetch is granted on every second contended cycle.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with both reqs = 1 -> all gnt/en/rvalid = 0 and o_stall = 1; release -> data is granted first.
- Fetch only: i_if_addr = 0x0000_1004, mem returns 0xDEADBEEF -> o_mem_addr = 0x0004 and gnt in the same cycle; the next cycle has o_if_rvalid = 1 and o_if_rdata = 0xDEADBEEF, and o_d_rvalid = 0.
- Store then load: store i_d_addr = 0x10, be = 4'b0011, wdata = 0x1234_5678 -> o_mem_addr = 0x1010, o_mem_we = 1, o_mem_be = 4'b0011, and no rvalid. The following load of 0x10 -> o_d_rvalid one cycle later.
- Fixed priority, MAX_WAIT = 4, both reqs held high -> grants are D,D,D,D,F repeating; o_stall = 1 every cycle; rvalid owners match grants with a 1-cycle lag.
- Round-robin (RR_MODE = 1), both reqs held high for 6 cycles -> grants are D,F,D,F,D,F; back-to-back rvalids are routed to the correct port.
- Pull rst_n low in the cycle after a fetch grant -> o_if_rvalid stays 0; rr_ptr and wait_cnt return to 0.
